// File: rtl/mem_sweep_arbiter.sv
// Owns one 1-cycle-latency, read-first block RAM and shares its read port between host reads and a
// checksum sweep over every word; the write port belongs to the host alone.
module mem_sweep_arbiter #(
    parameter int WID_MEM    = 15,
    parameter int DEPTH_MEM  = 1024,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               host_req,
    input  logic               host_we,
    input  logic [31:0]        host_addr,
    input  logic [WID_MEM-1:0] host_wdata,
    output logic               host_gnt,
    output logic               host_rvalid,
    output logic [WID_MEM-1:0] host_rdata,
    input  logic               sweep_start,
    output logic               sweep_busy,
    output logic               sweep_done,
    output logic [31:0]        sweep_sum,
    output logic [WID_MEM-1:0] sweep_xor,
    output logic [31:0]        mem_raddr,
    input  logic [WID_MEM-1:0] mem_dout,
    output logic               mem_we,
    output logic [31:0]        mem_waddr,
    output logic [WID_MEM-1:0] mem_din,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_DONE} state_t;

    localparam int              CW       = $clog2(STARVE_MAX + 1);
    localparam logic [31:0]     DEPTH_W  = 32'(DEPTH_MEM);
    localparam logic [31:0]     LAST_W   = 32'(DEPTH_MEM - 1);
    localparam logic [CW-1:0]   STARVE_W = CW'(STARVE_MAX);

    state_t             r_state;
    logic [31:0]        r_ptr;
    logic [CW-1:0]      r_starve_cnt;
    logic               r_rd_inflight;
    logic               r_host_rvalid;
    logic               r_host_in_range;
    logic               r_busy;
    logic               r_done;
    logic [31:0]        r_sum;
    logic [WID_MEM-1:0] r_xor;

    logic w_in_sweep;
    logic w_host_rd;
    logic w_starved;
    logic w_host_rd_gnt;
    logic w_sweep_rd;
    logic w_in_range;

    // Valid/ready: host_req is a one-cycle offer; host_gnt in the same cycle means it was taken.
    // A refused host read is lost and must be re-requested. Read data follows a granted read by one cycle.
    assign w_in_sweep    = (r_state == S_SWEEP);
    assign w_host_rd     = host_req & ~host_we;
    assign w_starved     = w_in_sweep & (r_starve_cnt == STARVE_W);
    assign w_host_rd_gnt = w_host_rd & ~w_starved & ~reset;
    assign w_sweep_rd    = w_in_sweep & (~w_host_rd | w_starved) & ~reset;
    assign w_in_range    = (host_addr < DEPTH_W);

    assign host_gnt  = host_req & ~reset & (host_we | ~w_starved);
    assign mem_we    = host_req & host_we & w_in_range & ~reset;
    assign mem_waddr = mem_we ? host_addr : '0;
    assign mem_din   = mem_we ? host_wdata : '0;
    assign mem_raddr = w_sweep_rd ? r_ptr : (w_host_rd_gnt ? host_addr : '0);

    // Out-of-range reads still complete, returning zero instead of whatever the RAM drives.
    assign host_rvalid = r_host_rvalid;
    assign host_rdata  = (r_host_rvalid & r_host_in_range) ? mem_dout : '0;

    assign sweep_busy = r_busy;
    assign sweep_done = r_done;
    assign sweep_sum  = r_sum;
    assign sweep_xor  = r_xor;
    assign dbg_state  = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_ptr           <= '0;
            r_starve_cnt    <= '0;
            r_rd_inflight   <= 1'b0;
            r_host_rvalid   <= 1'b0;
            r_host_in_range <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_sum           <= '0;
            r_xor           <= '0;
        end else begin
            r_host_rvalid   <= w_host_rd_gnt;
            r_host_in_range <= w_in_range;
            r_rd_inflight   <= w_sweep_rd;

            if (r_rd_inflight) begin
                r_sum <= r_sum + 32'(mem_dout);
                r_xor <= r_xor ^ mem_dout;
            end

            if (!w_in_sweep || w_sweep_rd) begin
                r_starve_cnt <= '0;
            end else if (w_host_rd_gnt) begin
                r_starve_cnt <= r_starve_cnt + CW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (sweep_start) begin
                        r_state <= S_SWEEP;
                        r_ptr   <= '0;
                        r_sum   <= '0;
                        r_xor   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_SWEEP: begin
                    if (w_sweep_rd) begin
                        r_ptr <= r_ptr + 32'd1;
                        if (r_ptr == LAST_W) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Last word lands this cycle; done is raised for the following one.
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
